tpg_frame_scheduler: RTL and testbench
======================================

Name: tpg_frame_scheduler

Overview:
- Sequencing controller for the test pattern generator datapath.
- Produces the pixel-coordinate stream (x, y) with AXI4-Stream video sideband signals: valid, start-of-frame (tuser) and end-of-line (tlast).
- Selects which colour pattern the downstream colour generator renders for each frame, rotating through an enabled set of patterns.
- Schedules runs of N frames or continuous output, with a programmable idle gap between frames.

Parameters:
- H_ACTIVE, 1280, pixels per line.
- V_ACTIVE, 720, lines per frame.
- GAP_CYCLES, 16, idle cycles between frames (o_valid low); 0 means back-to-back frames.
- NUM_PAT, 4, number of selectable patterns; pattern index width is PAT_W = $clog2(NUM_PAT).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- i_enable  in  1  run request (level).
- i_num_frames  in  16  frames per run; 0 means continuous; sampled on the IDLE->ACTIVE transition.
- i_pattern_mask  in  NUM_PAT  enabled patterns; sampled at each frame start.
- m_ready  in  1  downstream ready.
- o_valid  out  1  beat valid.
- o_x  out  $clog2(H_ACTIVE)  pixel column.
- o_y  out  $clog2(V_ACTIVE)  line number.
- o_start  out  1  high on beat (0,0) only.
- o_last  out  1  high on beat x = H_ACTIVE-1.
- o_pattern  out  PAT_W  pattern index for the current frame.
- o_busy  out  1  high when not IDLE.
- o_frame_done  out  1  one-cycle pulse after the last beat of each frame.
- o_run_done  out  1  one-cycle pulse when a finite run completes.
- o_frame_cnt  out  16  frames completed in the current run.

Behaviour:
- Reset: clock clk; reset resetn, synchronous, active-low. During reset, all outputs are 0 and state is IDLE. Reset mid-frame aborts immediately with no trailing beats.
- State IDLE -> ACTIVE: when i_enable = 1. On this transition the block latches i_num_frames, clears o_frame_cnt, selects the pattern, sets x = y = 0, and asserts o_valid on the next cycle (one-cycle latency from enable to the first valid beat).
- Transfer rule: a transfer occurs on a cycle with o_valid & m_ready. While o_valid & !m_ready, o_x, o_y, o_start, o_last and o_pattern hold stable. o_valid never drops mid-frame.
- Counters:
  - Each transfer increments x.
  - At x = H_ACTIVE-1, x wraps to 0 and y increments.
  - The transfer at (H_ACTIVE-1, V_ACTIVE-1) ends the frame.
- Frame end actions: pulse o_frame_done and increment o_frame_cnt (wraps at 16 bits). Then the next state is chosen as follows:
  - If the run is finite and the count equals the latched N: go to IDLE and pulse o_run_done in the same cycle as o_frame_done.
  - Else if i_enable = 0: go to IDLE without o_run_done. A run in progress always completes the current frame; deasserting enable never truncates a frame.
  - Else if GAP_CYCLES > 0: go to GAP.
  - Otherwise: start the next frame directly in ACTIVE with no bubble (o_valid stays 1).
- GAP: o_valid = 0 for exactly GAP_CYCLES cycles, then return to ACTIVE with a new pattern selected. If i_enable drops during GAP, go to IDLE when the gap expires.
- Pattern selection at each frame start: choose the next set bit of i_pattern_mask strictly after the current o_pattern, wrapping modulo NUM_PAT.
  - If only the current bit is set, reselect it.
  - If the mask is 0, select 0.
  - The first frame after reset searches from index NUM_PAT-1, so it picks the lowest set bit.
  - o_pattern is constant for the whole frame.
- o_busy = 1 in ACTIVE and GAP.

Optional Feature:
- TPG_SCHED_STALL_CNT_EN.
- Defined: adds output o_stall_cnt (32 bits), which counts cycles with o_valid & !m_ready. It saturates at all-ones, clears on reset and on IDLE->ACTIVE, and holds in IDLE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- H=8, V=4, GAP=2, N=1, mask=4'b0101, m_ready=1: exactly 32 beats; o_start only on beat 0; o_last on beats 7, 15, 23, 31; o_pattern = 0; o_frame_done and o_run_done pulse together; then IDLE with o_busy = 0.
- Same parameters with N=3: 2 invalid cycles between frames; o_pattern sequence 0, 2, 0; o_frame_cnt ends at 3.
- Random m_ready at 50% with N=1: outputs stable during every stall; still exactly 32 transfers with correct x/y ordering. With TPG_SCHED_STALL_CNT_EN defined, o_stall_cnt equals the bench-counted stall cycles.
- N=0 (continuous) with GAP=0: frames are back-to-back with o_valid never low. Drop i_enable at beat (3,1): the frame completes to (7,3), then IDLE with no o_run_done.
- resetn asserted at beat (4,2): the next cycle shows o_valid = 0 and all outputs 0. A new enable restarts at (0,0) with o_start = 1 and o_frame_cnt = 0.
- mask=0, then mask changed to 4'b1000 during frame 1 (N=2): frame 1 shows o_pattern = 0 and frame 2 shows o_pattern = 3.

Source files
------------

// File: rtl/tpg_frame_scheduler.sv
// tpg_frame_scheduler: sequencing controller for the test pattern generator.
//   Emits the (x, y) pixel-coordinate beat stream with AXI4-Stream video
//   sideband (valid, start-of-frame, end-of-line). It also picks the colour
//   pattern for each frame by rotating through the enabled set, and schedules
//   runs of N frames (or continuous output) with an idle gap between frames.
//   Latency: one cycle from i_enable to the first valid beat. Outputs are
//   registered, or decoded directly from registered state.
//   Backpressure: while o_valid & !m_ready, beat fields hold. o_valid never
//   drops inside a frame.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   i_enable               run request (level)
//   i_num_frames           frames per run (0 = continuous), latched at run start
//   i_pattern_mask         enabled patterns, sampled at every frame start
//   m_ready                downstream ready
//   o_valid/o_x/o_y        beat valid and pixel coordinates
//   o_start/o_last         start-of-frame (0,0) / end-of-line (x = H_ACTIVE-1)
//   o_pattern              pattern index for the current frame
//   o_busy                 high in ACTIVE and GAP
//   o_frame_done           one-cycle pulse after the last beat of a frame
//   o_run_done             one-cycle pulse when a finite run completes
//   o_frame_cnt            frames completed in the current run
//   o_stall_cnt            only with TPG_SCHED_STALL_CNT_EN defined: saturating
//                          count of o_valid & !m_ready cycles in the current run
module tpg_frame_scheduler #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int GAP_CYCLES = 16,
  parameter int NUM_PAT    = 4,
  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int PAT_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_enable,
  input  logic [15:0]        i_num_frames,
  input  logic [NUM_PAT-1:0] i_pattern_mask,
  input  logic               m_ready,
  output logic               o_valid,
  output logic [XW-1:0]      o_x,
  output logic [YW-1:0]      o_y,
  output logic               o_start,
  output logic               o_last,
  output logic [PAT_W-1:0]   o_pattern,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_run_done,
  output logic [15:0]        o_frame_cnt
`ifdef TPG_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t             state;
  logic [15:0]        num_lat;
  logic [GW-1:0]      gap_cnt;
  // Search origin for the next pattern. Separate from o_pattern because
  // o_pattern resets to 0, but the first frame after reset must search from
  // NUM_PAT-1 so that it lands on the lowest enabled pattern.
  logic [PAT_W-1:0]   pat_base;
  logic [PAT_W-1:0]   sel_pat;
  logic [15:0]        frame_cnt_nxt;
  logic               x_end;
  logic               y_end;
  logic               run_end;
  logic               xfer;

  // Next set mask bit strictly after cur, wrapping. When i == NUM_PAT the
  // search lands back on cur itself, which covers the single-bit case. An
  // empty mask selects 0.
  function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] cur,
                                               input logic [NUM_PAT-1:0] mask);
    logic [PAT_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PAT; i++) begin
      idx = (int'(cur) + i) % NUM_PAT;
      if (!found && mask[idx]) begin
        res   = PAT_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign sel_pat       = next_pat(pat_base, i_pattern_mask);
  assign x_end         = (o_x == XW'(H_ACTIVE - 1));
  assign y_end         = (o_y == YW'(V_ACTIVE - 1));
  assign xfer          = o_valid && m_ready;
  assign frame_cnt_nxt = o_frame_cnt + 16'd1;
  assign run_end       = (num_lat != 16'd0) && (frame_cnt_nxt == num_lat);

  // Sideband is decoded from registered coordinates, so it holds across stalls.
  assign o_start = o_valid && (o_x == '0) && (o_y == '0);
  assign o_last  = o_valid && x_end;
  assign o_busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      o_valid      <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_pattern    <= '0;
      pat_base     <= PAT_W'(NUM_PAT - 1);
      o_frame_done <= 1'b0;
      o_run_done   <= 1'b0;
      o_frame_cnt  <= '0;
      num_lat      <= '0;
      gap_cnt      <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_run_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_enable) begin
            state       <= S_ACTIVE;
            o_valid     <= 1'b1;
            o_x         <= '0;
            o_y         <= '0;
            num_lat     <= i_num_frames;
            o_frame_cnt <= '0;
            o_pattern   <= sel_pat;
            pat_base    <= sel_pat;
          end
        end
        S_ACTIVE: begin
          if (xfer) begin
            if (x_end) begin
              o_x <= '0;
              if (y_end) begin
                o_y          <= '0;
                o_frame_done <= 1'b1;
                o_frame_cnt  <= frame_cnt_nxt;
                if (run_end) begin
                  state      <= S_IDLE;
                  o_valid    <= 1'b0;
                  o_run_done <= 1'b1;
                end else if (!i_enable) begin
                  state   <= S_IDLE;
                  o_valid <= 1'b0;
                end else if (GAP_CYCLES > 0) begin
                  state   <= S_GAP;
                  o_valid <= 1'b0;
                  gap_cnt <= GW'(GAP_LOAD);
                end else begin
                  // Back-to-back: valid stays high, next frame starts now.
                  o_pattern <= sel_pat;
                  pat_base  <= sel_pat;
                end
              end else begin
                o_y <= o_y + YW'(1);
              end
            end else begin
              o_x <= o_x + XW'(1);
            end
          end
        end
        S_GAP: begin
          // gap_cnt is loaded with GAP_CYCLES-1, so the decrement cycles plus
          // this exit cycle give exactly GAP_CYCLES cycles with valid low.
          if (gap_cnt == '0) begin
            if (i_enable) begin
              state     <= S_ACTIVE;
              o_valid   <= 1'b1;
              o_pattern <= sel_pat;
              pat_base  <= sel_pat;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TPG_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_stall_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (i_enable) o_stall_cnt <= '0;
    end else if (o_valid && !m_ready && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpg_frame_scheduler.sv
// tb_tpg_frame_scheduler: directed bench for tpg_frame_scheduler on an 8x4
//   raster. The dut instance uses a 2-cycle gap; the dut0 instance uses no gap,
//   to exercise continuous back-to-back frames.
module tb_tpg_frame_scheduler;
  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        en1, en0, m_ready;
  logic [15:0] num_frames;
  logic [3:0]  mask;

  logic        v1_valid, v1_start, v1_last, v1_busy, v1_frame_done, v1_run_done;
  logic [2:0]  v1_x;
  logic [1:0]  v1_y, v1_pattern;
  logic [15:0] v1_frame_cnt;
  logic        v0_valid, v0_start, v0_last, v0_busy, v0_frame_done, v0_run_done;
  logic [2:0]  v0_x;
  logic [1:0]  v0_y, v0_pattern;
  logic [15:0] v0_frame_cnt;
`ifdef TPG_SCHED_STALL_CNT_EN
  logic [31:0] v1_stall, v0_stall;
`endif

  int total = 0;
  int bad   = 0;

  tpg_frame_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(2), .NUM_PAT(4)) dut (
    .clk(clk), .resetn(resetn), .i_enable(en1), .i_num_frames(num_frames),
    .i_pattern_mask(mask), .m_ready(m_ready), .o_valid(v1_valid), .o_x(v1_x),
    .o_y(v1_y), .o_start(v1_start), .o_last(v1_last), .o_pattern(v1_pattern),
    .o_busy(v1_busy), .o_frame_done(v1_frame_done), .o_run_done(v1_run_done),
    .o_frame_cnt(v1_frame_cnt)
`ifdef TPG_SCHED_STALL_CNT_EN
    , .o_stall_cnt(v1_stall)
`endif
  );

  tpg_frame_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(0), .NUM_PAT(4)) dut0 (
    .clk(clk), .resetn(resetn), .i_enable(en0), .i_num_frames(num_frames),
    .i_pattern_mask(mask), .m_ready(m_ready), .o_valid(v0_valid), .o_x(v0_x),
    .o_y(v0_y), .o_start(v0_start), .o_last(v0_last), .o_pattern(v0_pattern),
    .o_busy(v0_busy), .o_frame_done(v0_frame_done), .o_run_done(v0_run_done),
    .o_frame_cnt(v0_frame_cnt)
`ifdef TPG_SCHED_STALL_CNT_EN
    , .o_stall_cnt(v0_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] m);
    @(negedge clk);
    resetn = 1'b0; en1 = 1'b0; en0 = 1'b0; m_ready = 1'b1; mask = m; num_frames = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {v1_valid, v1_x, v1_y, v1_start, v1_last, v1_pattern, v1_busy,
                      v1_frame_done, v1_run_done, v1_frame_cnt}, 32'd0);
    resetn = 1'b1;
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    num_frames = 16'(n); en1 = 1'b1; m_ready = 1'b1;
  endtask

  // Follows one run on dut: checks every transfer against the raster model,
  // beat stability across stalls, pulses, counts and the gap length.
  task automatic mon1(input int nfr, input int p0, input int p1, input int p2,
                      input bit rnd, input bit mask_sw);
    int ex, ey, fr, beats, gaps, stalls;
    int pats[3];
    bit done, stalled;
    logic [9:0] cur, hold, exp;
    ex = 0; ey = 0; fr = 0; beats = 0; gaps = 0; stalls = 0;
    done = 1'b0; stalled = 1'b0; hold = '0;
    pats[0] = p0; pats[1] = p1; pats[2] = p2;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      cur = {v1_valid, v1_pattern, v1_start, v1_last, v1_y, v1_x};
      if (cyc == 0) begin
        chk("first_valid", v1_valid, 1);
        chk("cnt_clr", v1_frame_cnt, 0);
      end
      if (stalled) chk("hold", cur, hold);
      stalled = 1'b0;
      if (v1_frame_done) begin
        chk("run_done", v1_run_done, (fr == nfr));
        chk("frame_cnt", v1_frame_cnt, fr);
        if (fr == nfr) begin
          done = 1'b1;
          en1  = 1'b0;
        end
      end else begin
        chk("no_run_done", v1_run_done, 0);
      end
      if (v1_busy && !v1_valid) gaps++;
      if (v1_valid) begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_ready) begin
          exp = {1'b1, 2'((fr < 3) ? pats[fr] : 0), (ex == 0 && ey == 0), (ex == H - 1),
                 2'(ey), 3'(ex)};
          chk("beat", cur, exp);
          beats++;
          if (mask_sw && beats == 5) mask = 4'b1000;
          ex++;
          if (ex == H) begin
            ex = 0; ey++;
            if (ey == V) begin ey = 0; fr++; end
          end
        end else begin
          stalled = 1'b1;
          hold = cur;
          stalls++;
        end
      end
    end
    chk("timeout", done, 1);
    chk("beats", beats, 32 * nfr);
    chk("gap_cycles", gaps, 2 * (nfr - 1));
`ifdef TPG_SCHED_STALL_CNT_EN
    chk("stall_cnt", v1_stall, stalls);
`endif
    m_ready = 1'b1;
    @(negedge clk);
    chk("idle", {v1_busy, v1_valid, v1_run_done, v1_frame_done}, 0);
    chk("cnt_hold", v1_frame_cnt, nfr);
  endtask

  // Continuous run on dut0 (no gap): enable dropped at beat (3,1) of frame 1.
  task automatic mon0();
    int ex, ey, fr, beats, lows, dones;
    int pats[2];
    bit done;
    logic [9:0] cur, exp;
    ex = 0; ey = 0; fr = 0; beats = 0; lows = 0; dones = 0; done = 1'b0;
    pats[0] = 0; pats[1] = 2;
    @(negedge clk);
    num_frames = 16'd0; en0 = 1'b1; m_ready = 1'b1;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      @(negedge clk);
      cur = {v0_valid, v0_pattern, v0_start, v0_last, v0_y, v0_x};
      if (v0_frame_done) begin
        dones++;
        chk("c_run_done", v0_run_done, 0);
        chk("c_cnt", v0_frame_cnt, dones);
        if (dones == 2) done = 1'b1;
      end
      if (fr < 2 && !v0_valid) lows++;
      if (v0_valid) begin
        exp = {1'b1, 2'((fr < 2) ? pats[fr] : 0), (ex == 0 && ey == 0), (ex == H - 1),
               2'(ey), 3'(ex)};
        chk("c_beat", cur, exp);
        beats++;
        if (fr == 1 && ex == 3 && ey == 1) en0 = 1'b0;
        ex++;
        if (ex == H) begin
          ex = 0; ey++;
          if (ey == V) begin ey = 0; fr++; end
        end
      end
    end
    chk("c_timeout", done, 1);
    chk("c_beats", beats, 64);
    chk("c_valid_low", lows, 0);
    @(negedge clk);
    chk("c_idle", {v0_busy, v0_valid, v0_run_done}, 0);
  endtask

  initial begin
    bit found;
    resetn = 1'b0; en1 = 1'b0; en0 = 1'b0; m_ready = 1'b1; mask = 4'b0101; num_frames = '0;

    // Single frame, always ready.
    do_reset(4'b0101);
    start_run(1);
    mon1(1, 0, 0, 0, 1'b0, 1'b0);

    // Three frames: patterns rotate 0, 2, 0 with a 2-cycle gap.
    do_reset(4'b0101);
    start_run(3);
    mon1(3, 0, 2, 0, 1'b0, 1'b0);

    // Single frame under random backpressure.
    do_reset(4'b0101);
    start_run(1);
    mon1(1, 0, 0, 0, 1'b1, 1'b0);

    // Continuous, back-to-back, stop by dropping enable mid-frame.
    do_reset(4'b0101);
    mon0();

    // Reset in the middle of a frame, then restart.
    do_reset(4'b0101);
    start_run(1);
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (v1_valid && v1_x == 3'd4 && v1_y == 2'd2) found = 1'b1;
    end
    chk("reach_4_2", found, 1);
    resetn = 1'b0; en1 = 1'b0;
    @(negedge clk);
    chk("reset_mid", {v1_valid, v1_x, v1_y, v1_start, v1_last, v1_pattern, v1_busy,
                      v1_frame_done, v1_run_done, v1_frame_cnt}, 32'd0);
    resetn = 1'b1;
    start_run(1);
    mon1(1, 0, 0, 0, 1'b0, 1'b0);

    // Empty mask in frame 1, mask switched to 4'b1000 mid-frame.
    do_reset(4'b0000);
    start_run(2);
    mon1(2, 0, 3, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
